// File: rtl/issue_pkg.sv
// Shared constants and types for the ID-stage issue controller and its hazard check.
package issue_pkg;

  localparam int NREG = 8;
  localparam int ADRW = 3;

  typedef logic [ADRW-1:0] reg_adr_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/issue_ctrl_if.sv
// ID-stage <-> issue controller bundle: decoded operands, scoreboard view, control and status.
// Flow is level-based, not valid/ready: issue=1 in a cycle means the ID instruction is taken
// into EX at the next edge; id_stall=1 means IF/ID must hold; neither waits on the other side.
interface issue_ctrl_if import issue_pkg::*; #(
  parameter int CNT_W = 16
) ();

  logic            id_valid;
  reg_adr_t        id_rs_adr;
  logic            id_rs_use;
  reg_adr_t        id_rt_adr;
  logic            id_rt_use;
  reg_adr_t        id_rd_adr;
  logic            id_rd_we;
  logic [NREG-1:0] register_invalid;
  logic            regwrite;
  reg_adr_t        regwrite_adr;
  logic            br_taken;
  logic            halt;

  logic            issue;
  logic            id_stall;
  logic            regwrite_cur;
  reg_adr_t        regwrite_adr_id;
  logic            flush;
  logic            halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] issue_count;
  state_t          dbg_state;

  modport master (
    output id_valid, id_rs_adr, id_rs_use, id_rt_adr, id_rt_use, id_rd_adr, id_rd_we,
    output register_invalid, regwrite, regwrite_adr, br_taken, halt,
    input  issue, id_stall, regwrite_cur, regwrite_adr_id, flush, halted,
    input  stall_cycles, issue_count, dbg_state
  );

  modport slave (
    input  id_valid, id_rs_adr, id_rs_use, id_rt_adr, id_rt_use, id_rd_adr, id_rd_we,
    input  register_invalid, regwrite, regwrite_adr, br_taken, halt,
    output issue, id_stall, regwrite_cur, regwrite_adr_id, flush, halted,
    output stall_cycles, issue_count, dbg_state
  );

endinterface

// File: rtl/issue_ctrl_hazard_check.sv
// Combinational register-busy check for one instruction, with same-cycle writeback bypass.
module hazard_check import issue_pkg::*; (
  input  logic            id_valid_i,
  input  reg_adr_t        rs_adr_i,
  input  logic            rs_use_i,
  input  reg_adr_t        rt_adr_i,
  input  logic            rt_use_i,
  input  reg_adr_t        rd_adr_i,
  input  logic            rd_we_i,
  input  logic [NREG-1:0] register_invalid_i,
  input  logic            regwrite_i,
  input  reg_adr_t        regwrite_adr_i,
  output logic            hazard_o
);

  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] busy;

  // A register being written back this cycle is already readable.
  assign wb_mask = regwrite_i ? (NREG'(1) << regwrite_adr_i) : '0;
  assign busy    = register_invalid_i & ~wb_mask;

  // The rd term blocks WAW: the scoreboard cannot track two pending writes to one register.
  assign hazard_o = id_valid_i & ((rs_use_i & busy[rs_adr_i]) |
                                  (rt_use_i & busy[rt_adr_i]) |
                                  (rd_we_i  & busy[rd_adr_i]));

endmodule

// File: rtl/issue_ctrl.sv
// Issue decision for the ID stage: scoreboard hazards, branch squash, halt and perf counters.
module issue_ctrl import issue_pkg::*; #(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  issue_ctrl_if.slave  bus
);

  localparam int FCW = ($clog2(FLUSH_CYC) > 0) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYC - 1);

  state_t           state_q, state_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, issue_q;

  logic hazard;
  logic issue_c, stall_c, flush_c, halted_c, stall_inc;

  hazard_check u_hazard (
    .id_valid_i         (bus.id_valid),
    .rs_adr_i           (bus.id_rs_adr),
    .rs_use_i           (bus.id_rs_use),
    .rt_adr_i           (bus.id_rt_adr),
    .rt_use_i           (bus.id_rt_use),
    .rd_adr_i           (bus.id_rd_adr),
    .rd_we_i            (bus.id_rd_we),
    .register_invalid_i (bus.register_invalid),
    .regwrite_i         (bus.regwrite),
    .regwrite_adr_i     (bus.regwrite_adr),
    .hazard_o           (hazard)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      stall_q <= '0;
      issue_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (issue_c) begin
        issue_q <= issue_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    issue_c   = 1'b0;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    halted_c  = 1'b0;
    stall_inc = 1'b0;

    case (state_q)
      RUN, STALL: begin
        issue_c   = bus.id_valid & ~hazard;
        stall_c   = hazard;
        stall_inc = hazard;
        state_d   = hazard ? STALL : RUN;
        if (bus.br_taken) begin
          issue_c = 1'b0;
          flush_c = 1'b1;
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (bus.br_taken) begin
          fcnt_d = FLUSH_LOAD;
        end else if (fcnt_q == '0) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      HALT: begin
        stall_c  = 1'b1;
        halted_c = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Halt outranks branch squash and hazards.
    if (bus.halt && (state_q != HALT)) begin
      issue_c = 1'b0;
      state_d = HALT;
    end

    if (reset) begin
      issue_c   = 1'b0;
      stall_c   = 1'b0;
      flush_c   = 1'b0;
      halted_c  = 1'b0;
      stall_inc = 1'b0;
    end
  end

  assign bus.issue           = issue_c;
  assign bus.id_stall        = stall_c;
  assign bus.flush           = flush_c;
  assign bus.halted          = halted_c;
  // The scoreboard sets the claimed bit at this same edge.
  assign bus.regwrite_cur    = issue_c & bus.id_rd_we;
  assign bus.regwrite_adr_id = reset ? '0 : bus.id_rd_adr;
  assign bus.stall_cycles    = stall_q;
  assign bus.issue_count     = issue_q;
  assign bus.dbg_state       = state_q;

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Reader side of the register-invalid scoreboard: decides each cycle whether the instruction in ID may issue into EX.
- Checks source/destination registers against the 8-bit register_invalid vector, with same-cycle writeback bypass.
- On issue, drives the scoreboard's claim inputs (regwrite_cur, regwrite_adr_id).
- Handles taken-branch squash and halt, and keeps stall/issue performance counters.

Parameters:
NREG, 8, number of architectural registers (scoreboard width)
ADRW, 3, register address width, log2(NREG)
FLUSH_CYC, 2, cycles of issue squash after a taken branch (>=1)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
id_valid  in  1  ID stage holds a valid instruction
id_rs_adr  in  ADRW  source register 1 address
id_rs_use  in  1  instruction reads rs
id_rt_adr  in  ADRW  source register 2 address
id_rt_use  in  1  instruction reads rt
id_rd_adr  in  ADRW  destination register address
id_rd_we  in  1  instruction writes rd
register_invalid  in  NREG  scoreboard vector, 1 = write pending
regwrite  in  1  writeback this cycle
regwrite_adr  in  ADRW  writeback register address
br_taken  in  1  EX resolved a taken branch this cycle
halt  in  1  halt request
issue  out  1  ID instruction advances to EX this cycle
id_stall  out  1  hold IF/ID registers this cycle
regwrite_cur  out  1  claim rd in scoreboard (= issue & id_rd_we)
regwrite_adr_id  out  ADRW  claimed address (= id_rd_adr)
flush  out  1  squash IF/ID contents this cycle
halted  out  1  core halted
stall_cycles  out  CNT_W  cycles lost to data hazards, saturating
issue_count  out  CNT_W  issued instructions, wrapping

Behaviour:
- Busy(r) = register_invalid[r] & ~(regwrite & regwrite_adr==r). A writeback in the same cycle bypasses the busy bit.
- Hazard = id_valid & ((id_rs_use & busy(rs)) | (id_rt_use & busy(rt)) | (id_rd_we & busy(rd))). The rd term blocks WAW, because the scoreboard has one bit per register.
- States: RUN, STALL, FLUSH, HALT. Reset -> RUN.
- RUN/STALL:
  - issue = id_valid & ~hazard.
  - id_stall = hazard.
  - Next state STALL if hazard, else RUN.
- Transition priority at each edge: reset > halt > br_taken > hazard.
- br_taken (in RUN or STALL):
  - Next state FLUSH; internal flush counter loads FLUSH_CYC-1.
  - issue is forced 0 in the br_taken cycle.
  - flush=1 in the br_taken cycle and in every FLUSH cycle.
- FLUSH:
  - issue=0, id_stall=0, flush=1.
  - Counter decrements; at 0, next state RUN.
  - br_taken in FLUSH reloads the counter.
- halt (any state except HALT): next state HALT; issue forced 0 in the halt cycle.
- HALT: issue=0, id_stall=1, halted=1. Absorbing until reset.
- regwrite_cur and regwrite_adr_id are combinational. The scoreboard sets the bit at the same edge, so the next ID instruction sees it one cycle later.
  - Back-to-back dependents therefore stall until writeback.
  - Writeback and claim of the same register in one cycle: claim wins, matching scoreboard set-after-clear ordering.
- stall_cycles: +1 per cycle with hazard in RUN/STALL; saturates at all-ones.
- issue_count: +1 per issue; wraps to 0.
- Reset outputs: issue=0, id_stall=0, regwrite_cur=0, flush=0, halted=0, counters=0. Combinational outputs are forced 0 while reset is high.
- Reset mid-FLUSH or mid-STALL returns to RUN the next cycle with counters cleared.

Decomposition:
- Package issue_pkg holds:
  - NREG and ADRW constants.
  - State enum: RUN, STALL, FLUSH, HALT.
  - Register address typedef.
- Sub-module hazard_check: combinational busy/bypass logic producing hazard. It is reusable for a later dual-issue check.

Test Plan:
- register_invalid=0, id_valid=1, rs=1 used, rd=2 we -> issue=1, regwrite_cur=1, regwrite_adr_id=2, issue_count=1.
- register_invalid=8'b0000_0010, rs=1 used, 3 cycles, then regwrite=1 adr=1 on cycle 4 -> id_stall=1 for cycles 1-3, issue=1 on cycle 4 (bypass), stall_cycles=3.
- register_invalid bit 5 set, rd=5 we, rs unused -> WAW stall (issue=0) until writeback of r5.
- br_taken pulse with FLUSH_CYC=2, id_valid=1 and no hazard -> flush=1 for 3 consecutive cycles (pulse + 2), issue=0 throughout, RUN after.
- halt during STALL -> halted=1 next cycle, issue stays 0 despite clean scoreboard; reset -> halted=0, counters 0.
- Force 2^CNT_W+5 hazard cycles -> stall_cycles holds 16'hFFFF.
